// File: rtl/cla_serial_adder_pkg.sv
// Shared definitions for the digit-serial CLA adder.
//   SLICE_W : width of the combinational carry-lookahead slice (bits per cycle)
//   state_t : control FSM encoding (IDLE / RUN / DONE)
package cla_serial_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_serial_adder_cla.sv
// 4-bit carry-lookahead adder slice (the CLA block), purely combinational.
// Ports:
//   x, y  : 4-bit addends
//   cin   : carry into bit 0
//   s     : 4-bit sum
//   cout  : carry out of bit 3
module cla_serial_adder_cla
    import cla_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    assign g = x & y;
    assign p = x ^ y;

    // Every carry is expanded directly from generate/propagate terms so no
    // carry ripples through a previous carry.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];

endmodule

// File: rtl/cla_serial_adder.sv
// Digit-serial wide adder: adds two WIDTH-bit operands one 4-bit CLA slice per
// clock, least-significant slice first, with the carry held in a register
// between slices.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin captured on accept)
//   a, b, cin           : operands and carry-in to slice 0
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : registered result, carry out of MSB, signed overflow
module cla_serial_adder
    import cla_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
            $error("cla_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic               carry_reg;
    logic               a_msb;
    logic               b_msb;
    logic [CNT_W-1:0]   cnt;
    logic               cout_reg;
    logic               ovf_reg;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;
    logic               accept;
    logic               last_slice;
    // Sum shift register with the new slice prepended; taking the upper WIDTH
    // bits shifts right by one slice and also works when WIDTH == SLICE_W.
    logic [WIDTH+SLICE_W-1:0] sum_cat;

    cla_serial_adder_cla u_cla (
        .x    (a_sh[SLICE_W-1:0]),
        .y    (b_sh[SLICE_W-1:0]),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout)
    );

    assign accept     = (state == IDLE) && in_valid;
    assign last_slice = (cnt == CNT_W'(NSLICE - 1));
    assign sum_cat    = {slice_s, sum_sh};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture on accept, one slice per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry_reg <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cnt       <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_sh      <= a;
            b_sh      <= b;
            carry_reg <= cin;
            a_msb     <= a[WIDTH-1];
            b_msb     <= b[WIDTH-1];
            cnt       <= '0;
        end else if (state == RUN) begin
            a_sh      <= a_sh >> SLICE_W;
            b_sh      <= b_sh >> SLICE_W;
            sum_sh    <= sum_cat[WIDTH+SLICE_W-1:SLICE_W];
            carry_reg <= slice_cout;
            cnt       <= cnt + 1'b1;
            // cout/ovf are latched only on the final slice so the visible
            // result never moves at the acceptance edge.
            if (last_slice) begin
                cout_reg <= slice_cout;
                ovf_reg  <= (a_msb == b_msb) && (slice_s[SLICE_W-1] != a_msb);
            end
        end
    end

    assign sum  = sum_sh;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_cla_serial_adder.sv
module tb_cla_serial_adder;

    logic        clk = 1'b0;
    logic        rst;

    // WIDTH=16 instance
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    // WIDTH=4 instance
    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4;
    logic [3:0]  a4, b4, sum4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cla_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned and signed views.
    function automatic void model(input int w, input longint ua, input longint ub, input int ci,
                                  output logic [31:0] es, output logic ec, output logic eo);
        longint m, tot, sa, sb, st;
        m   = 64'sd1 << w;
        tot = ua + ub + longint'(ci);
        es  = 32'(tot % m);
        ec  = (tot >= m);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sb  = (ub >= m / 2) ? ub - m : ub;
        st  = sa + sb + longint'(ci);
        eo  = (st >= m / 2) || (st < -(m / 2));
    endfunction

    task automatic run_op16(input logic [15:0] ta, input logic [15:0] tbb, input logic tc,
                            input string name, input logic [15:0] esum, input logic ecout,
                            input logic eovf);
        int lat, busy;
        @(negedge clk);
        check({name, " in_ready idle"}, 32'(in_ready), 32'd1);
        a = ta; b = tbb; cin = tc; in_valid = 1'b1;
        @(posedge clk);
        lat = 0; busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            if (!in_ready) busy++;
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd4);
        check({name, " sum"}, 32'(sum), 32'(esum));
        check({name, " cout"}, 32'(cout), 32'(ecout));
        check({name, " ovf"}, 32'(ovf), 32'(eovf));
        check({name, " busy cycles"}, 32'(busy), 32'd5);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({name, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op4(input logic [3:0] ta, input logic [3:0] tbb, input logic tc,
                           input string name);
        logic [31:0] es;
        logic        ec, eo;
        int          lat;
        model(4, longint'(ta), longint'(tbb), int'(tc), es, ec, eo);
        @(negedge clk);
        a4 = ta; b4 = tbb; cin4 = tc; in_valid4 = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid4 = 1'b0;
            if (out_valid4) break;
            @(posedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd1);
        check({name, " sum"}, 32'(sum4), es);
        check({name, " cout"}, 32'(cout4), 32'(ec));
        check({name, " ovf"}, 32'(ovf4), 32'(eo));
        out_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready4 = 1'b0;
        check({name, " out_valid drop"}, 32'(out_valid4), 32'd0);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [15:0] ra, rb;
        logic        rc;
        logic [31:0] es;
        logic        ec, eo;
        int          lat;

        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset w4 in_ready", 32'(in_ready4), 32'd1);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 6; i++)
            run_op16(vecs[i].va, vecs[i].vb, vecs[i].vcin, $sformatf("vec%0d", i),
                     vecs[i].esum, vecs[i].ecout, vecs[i].eovf);

        // Random against the integer model
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            model(16, longint'(ra), longint'(rb), int'(rc), es, ec, eo);
            run_op16(ra, rb, rc, $sformatf("rand%0d", i), es[15:0], ec, eo);
        end

        // Backpressure in DONE with a pending new operand
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 16'h0005; b = 16'h0003; cin = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp reach done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp sum hold%0d", i), 32'(sum), 32'h3333);
            check($sformatf("bp cout hold%0d", i), 32'(cout), 32'd0);
            check($sformatf("bp in_ready%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("bp out_valid%0d", i), 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp idle in_ready", 32'(in_ready), 32'd1);
        check("bp idle out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp accepted", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp new sum", 32'(sum), 32'h0008);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset in the second RUN cycle
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd1);
        check("async rst sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op16(16'h0008, 16'h0008, 1'b0, "after rst", 16'h0010, 1'b0, 1'b0);

        // WIDTH=4 instance
        run_op4(4'h8, 4'h8, 1'b1, "w4 8+8+1");
        check("w4 directed sum", 32'(sum4), 32'h1);
        for (int i = 0; i < 6; i++)
            run_op4(4'($urandom), 4'($urandom), 1'($urandom), $sformatf("w4 rand%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
